// File: rtl/game_ctrl.sv
// Game-level controller for the jumping-ball game: button debounce, hit/miss
// edge detection, BCD scoring, lives/speed tracking and the newgame/play/over FSM.
module game_ctrl #(
    parameter int DB_CYCLES   = 1000000,
    parameter int LIVES_INIT  = 3,
    parameter int SPEED_STEP  = 10,
    parameter int OVER_FRAMES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn,
    input  logic        frame_tick,
    input  logic        hit,
    input  logic        miss,
    output logic        gra_still,
    output logic [1:0]  speed,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic [1:0]  lives,
    output logic [1:0]  state,
    output logic        game_over
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int SSW = $clog2(SPEED_STEP + 1);
    localparam int OFW = $clog2(OVER_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_OVER    = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     score_q, score_d, high_q, high_d;
    logic [1:0]      lives_q, lives_d, speed_q, speed_d;
    logic [SSW-1:0]  land_q, land_d;
    logic [OFW-1:0]  over_cnt_q, over_cnt_d;
    logic            game_over_q, game_over_d, gra_still_q;
    logic            btn_s1_q, btn_s2_q, db_q, db_prev_q, hit_q, miss_q;
    logic [DBW-1:0]  db_cnt_q;
    logic            btn_press_s, hit_ev_s, miss_ev_s;

    // Increment a 4-digit BCD word with per-digit carry; 9999 wraps to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign btn_press_s = db_q & ~db_prev_q;
    assign hit_ev_s    = hit & ~hit_q;
    assign miss_ev_s   = miss & ~miss_q;

    // Button synchronizer, debouncer and input edge registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1_q  <= 1'b0;
            btn_s2_q  <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            db_cnt_q  <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            btn_s1_q  <= btn;
            btn_s2_q  <= btn_s1_q;
            db_prev_q <= db_q;
            hit_q     <= hit;
            miss_q    <= miss;
            if (btn_s2_q != db_q) begin
                if (db_cnt_q == DBW'(DB_CYCLES - 1)) begin
                    db_q     <= ~db_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    // Next-state and datapath update for the game FSM.
    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        high_d      = high_q;
        lives_d     = lives_q;
        speed_d     = speed_q;
        land_d      = land_q;
        over_cnt_d  = over_cnt_q;
        game_over_d = 1'b0;
        case (state_q)
            ST_NEWGAME: begin
                score_d = 16'h0000;
                lives_d = 2'(LIVES_INIT);
                speed_d = 2'd1;
                land_d  = '0;
                if (btn_press_s) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_NEWGAME;
                end
            end
            ST_PLAY: begin
                // A simultaneous hit is dropped: the miss takes priority.
                if (miss_ev_s) begin
                    lives_d = lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        state_d     = ST_OVER;
                        game_over_d = 1'b1;
                        over_cnt_d  = '0;
                        high_d      = (score_q > high_q) ? score_q : high_q;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end else if (hit_ev_s) begin
                    score_d = bcd_inc(score_q);
                    if (land_q == SSW'(SPEED_STEP - 1)) begin
                        land_d  = '0;
                        speed_d = (speed_q == 2'd3) ? 2'd3 : speed_q + 2'd1;
                    end else begin
                        land_d = land_q + 1'b1;
                    end
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (frame_tick && (over_cnt_q != OFW'(OVER_FRAMES))) begin
                    over_cnt_d = over_cnt_q + 1'b1;
                end else begin
                    over_cnt_d = over_cnt_q;
                end
                if (btn_press_s && (over_cnt_q == OFW'(OVER_FRAMES))) begin
                    state_d = ST_NEWGAME;
                    score_d = 16'h0000;
                    lives_d = 2'(LIVES_INIT);
                    speed_d = 2'd1;
                    land_d  = '0;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_NEWGAME;
            end
        endcase
    end

    // Game state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_NEWGAME;
            score_q     <= 16'h0000;
            high_q      <= 16'h0000;
            lives_q     <= 2'(LIVES_INIT);
            speed_q     <= 2'd1;
            land_q      <= '0;
            over_cnt_q  <= '0;
            game_over_q <= 1'b0;
            gra_still_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            high_q      <= high_d;
            lives_q     <= lives_d;
            speed_q     <= speed_d;
            land_q      <= land_d;
            over_cnt_q  <= over_cnt_d;
            game_over_q <= game_over_d;
            gra_still_q <= (state_d != ST_PLAY);
        end
    end

    assign gra_still  = gra_still_q;
    assign speed      = speed_q;
    assign score      = score_q;
    assign high_score = high_q;
    assign lives      = lives_q;
    assign state      = state_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: a transaction-level game model pushes expected
// snapshots, a negedge monitor pops and compares them against the DUT outputs.
module tb_game_ctrl;

    localparam int DB = 4;
    localparam int LI = 3;
    localparam int SS = 3;
    localparam int OF = 3;

    logic        clk = 1'b0;
    logic        reset, btn, frame_tick, hit, miss;
    logic        gra_still, game_over;
    logic [1:0]  speed, lives, state;
    logic [15:0] score, high_score;

    game_ctrl #(.DB_CYCLES(DB), .LIVES_INIT(LI), .SPEED_STEP(SS), .OVER_FRAMES(OF)) dut (
        .clk(clk), .reset(reset), .btn(btn), .frame_tick(frame_tick),
        .hit(hit), .miss(miss), .gra_still(gra_still), .speed(speed),
        .score(score), .high_score(high_score), .lives(lives),
        .state(state), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  st;
        logic        gs;
        logic [1:0]  sp;
        logic [15:0] sc;
        logic [15:0] hs;
        logic [1:0]  lv;
    } snap_t;

    snap_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int go_cycles = 0;

    // Game model: 0 newgame, 1 play, 2 over
    int m_state, m_score, m_high, m_lives, m_land, m_ticks, m_go;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: counts game_over cycles and checks the oldest pending snapshot.
    always @(negedge clk) begin
        snap_t e;
        if (game_over === 1'b1) go_cycles++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("state", int'(state), int'(e.st));
            cmp("gra_still", int'(gra_still), int'(e.gs));
            cmp("speed", int'(speed), int'(e.sp));
            cmp("score", int'(score), int'(e.sc));
            cmp("high_score", int'(high_score), int'(e.hs));
            cmp("lives", int'(lives), int'(e.lv));
        end
    end

    task automatic check();
        snap_t s;
        int sp;
        sp = 1 + m_land / SS;
        if (sp > 3) sp = 3;
        s.st = 2'(m_state);
        s.gs = (m_state != 1);
        s.sp = 2'(sp);
        s.sc = to_bcd(m_score);
        s.hs = to_bcd(m_high);
        s.lv = 2'(m_lives);
        exp_q.push_back(s);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_high = 0; m_lives = LI; m_land = 0; m_ticks = 0;
    endtask

    task automatic model_new();
        m_score = 0; m_lives = LI; m_land = 0;
    endtask

    task automatic model_miss();
        if (m_state == 1) begin
            m_lives--;
            if (m_lives == 0) begin
                m_state = 2;
                m_ticks = 0;
                m_go++;
                if (m_score > m_high) m_high = m_score;
            end
        end
    endtask

    task automatic do_hit(input int len, input int gap);
        hit = 1'b1;
        step(len);
        hit = 1'b0;
        step(gap);
        if (m_state == 1) begin
            m_score = (m_score + 1) % 10000;
            m_land++;
        end
    endtask

    task automatic do_miss(input int len, input int with_hit);
        miss = 1'b1;
        hit  = (with_hit != 0);
        step(len);
        miss = 1'b0;
        hit  = 1'b0;
        step(2);
        model_miss();
    endtask

    task automatic do_press();
        btn = 1'b1;
        step(10);
        btn = 1'b0;
        step(10);
        if (m_state == 0) begin
            m_state = 1;
            model_new();
        end else if (m_state == 2 && m_ticks >= OF) begin
            m_state = 0;
            model_new();
        end
    endtask

    task automatic do_bounce(input int len);
        btn = 1'b1;
        step(len);
        btn = 1'b0;
        step(6);
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(1);
        if (m_state == 2 && m_ticks < OF) m_ticks++;
    endtask

    initial begin
        int op;
        reset = 1'b1; btn = 1'b0; frame_tick = 1'b0; hit = 1'b0; miss = 1'b0;
        m_go = 0;
        model_reset();
        step(3);
        reset = 1'b0;
        check();
        step(2);

        // Bounce shorter than the debounce window, then a real press
        do_bounce(2); check();
        do_press(); check();

        // Three short hits step the speed, a long held hit counts once
        for (int i = 0; i < 3; i++) do_hit(5, 2);
        check();
        do_hit(50, 2); check();

        // Held miss counts once; hit and miss together: miss wins
        do_miss(100, 0); check();
        do_miss(1, 1); check();

        // Game over, then the ignore window on the button
        do_miss(3, 0); check();
        do_tick(); do_press(); check();
        do_tick(); do_tick(); do_press(); check();
        do_press(); check();

        // Score carries and wrap, speed saturation
        for (int i = 0; i < 100; i++) begin
            do_hit(1, 1);
            if (m_score == 9 || m_score == 10 || m_score == 99 || m_score == 100) check();
        end
        for (int i = 0; i < 10000; i++) begin
            do_hit(1, 1);
            if (m_score == 9999 || m_score == 0) check();
        end
        check();

        // Asynchronous reset between clock edges
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        check();
        step(1);
        reset = 1'b0;
        step(1);
        check();

        // Randomized play
        do_press(); check();
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2, 3, 4: do_hit(int'($urandom_range(1, 5)), int'($urandom_range(1, 3)));
                5:             do_miss(int'($urandom_range(1, 5)), 0);
                6:             do_miss(int'($urandom_range(1, 5)), 1);
                7:             do_press();
                8:             do_tick();
                default:       do_bounce(int'($urandom_range(1, 3)));
            endcase
            check();
        end

        step(3);
        cmp("game_over_cycles", go_cycles, m_go);
        cmp("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
